// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8x-oversampled UART receiver: state encoding,
// oversample timing indices and the 2-of-3 majority helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 8;

  // Samples straddle the bit centre; the voted bit is usable one cycle later.
  localparam logic [2:0] SAMPLE_A_IDX     = 3'd3;
  localparam logic [2:0] SAMPLE_B_IDX     = 3'd4;
  localparam logic [2:0] SAMPLE_C_IDX     = 3'd5;
  localparam logic [2:0] SAMPLE_VALID_IDX = 3'd6;
  localparam logic [2:0] BIT_END_IDX      = 3'(OVERSAMPLE - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority voter: captures RX_IN at the two early sample indices
// and registers the 2-of-3 vote at the third, holding it until the next vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [2:0] edge_cnt,
  input  logic       enable,
  output logic       sampled_bit
);

  logic sample_a_r;
  logic sample_b_r;
  logic sampled_bit_r;

  // Sample capture and vote register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sample_a_r    <= 1'b0;
      sample_b_r    <= 1'b0;
      sampled_bit_r <= 1'b0;
    end else if (enable) begin
      case (edge_cnt)
        SAMPLE_A_IDX: sample_a_r    <= RX_IN;
        SAMPLE_B_IDX: sample_b_r    <= RX_IN;
        SAMPLE_C_IDX: sampled_bit_r <= majority3(sample_a_r, sample_b_r, RX_IN);
        default: begin
          sample_a_r    <= sample_a_r;
          sample_b_r    <= sample_b_r;
          sampled_bit_r <= sampled_bit_r;
        end
      endcase
    end else begin
      sampled_bit_r <= sampled_bit_r;
    end
  end

  assign sampled_bit = sampled_bit_r;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller driving an external edge/bit counter; frames are
// start + DATA_WIDTH data bits (LSB first) + optional parity + stop.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [3:0]            bit_cnt,
  input  logic [2:0]            edge_cnt,
  output logic                  cnt_enable,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_t state_r;
  rx_state_t next_state_s;

  logic                  sampled_bit_s;
  logic                  bit_end_s;
  logic                  sample_pt_s;
  logic                  start_s;
  logic                  shift_s;
  logic                  par_chk_s;
  logic                  stp_chk_s;
  logic                  frame_end_s;
  logic                  cnt_en_s;
  logic                  frame_good_s;

  logic                  cnt_enable_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stp_err_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_flag_r;
  logic                  stp_flag_r;

  uart_rx_sampler u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .edge_cnt    (edge_cnt),
    .enable      (cnt_enable_r),
    .sampled_bit (sampled_bit_s)
  );

  assign bit_end_s    = (edge_cnt == BIT_END_IDX);
  assign sample_pt_s  = (edge_cnt == SAMPLE_VALID_IDX);
  assign frame_good_s = frame_end_s & ~par_flag_r & ~stp_flag_r;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-state datapath strobes
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    shift_s      = 1'b0;
    par_chk_s    = 1'b0;
    stp_chk_s    = 1'b0;
    frame_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (RX_IN == 1'b0) begin
          next_state_s = START;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        // A start bit that votes high was a line glitch.
        if (bit_end_s) begin
          next_state_s = sampled_bit_s ? IDLE : DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        shift_s = sample_pt_s;
        if (bit_end_s && (bit_cnt == 4'(DATA_WIDTH))) begin
          next_state_s = par_en_r ? PARITY : STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        par_chk_s = sample_pt_s;
        if (bit_end_s) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        stp_chk_s = sample_pt_s;
        if (bit_end_s) begin
          next_state_s = IDLE;
          frame_end_s  = 1'b1;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    cnt_en_s = (next_state_s != IDLE);
  end

  // Frame datapath, error flags and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_enable_r <= 1'b0;
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stp_err_r    <= 1'b0;
      p_data_r     <= '0;
      shift_r      <= '0;
      par_en_r     <= 1'b0;
      par_typ_r    <= 1'b0;
      par_flag_r   <= 1'b0;
      stp_flag_r   <= 1'b0;
    end else begin
      cnt_enable_r <= cnt_en_s;
      data_valid_r <= frame_good_s;
      par_err_r    <= frame_end_s & par_flag_r;
      stp_err_r    <= frame_end_s & stp_flag_r;
      if (start_s) begin
        par_en_r   <= PAR_EN;
        par_typ_r  <= PAR_TYP;
        par_flag_r <= 1'b0;
        stp_flag_r <= 1'b0;
      end else begin
        // Mismatch against XOR(data) for even, its inverse for odd.
        if (par_chk_s) begin
          par_flag_r <= sampled_bit_s ^ (^shift_r) ^ par_typ_r;
        end
        if (stp_chk_s) begin
          stp_flag_r <= ~sampled_bit_s;
        end
      end
      if (shift_s) begin
        shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
      end
      if (frame_good_s) begin
        p_data_r <= shift_r;
      end
    end
  end

  assign cnt_enable = cnt_enable_r;
  assign data_valid = data_valid_r;
  assign par_err    = par_err_r;
  assign stp_err    = stp_err_r;
  assign P_DATA     = p_data_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm paired with a behavioural edge/bit counter.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [3:0] bit_cnt;
  logic [2:0] edge_cnt;
  logic       cnt_enable;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;

  uart_rx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .bit_cnt    (bit_cnt),
    .edge_cnt   (edge_cnt),
    .cnt_enable (cnt_enable),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  // Edge/bit counter model: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= 3'd0;
      bit_cnt  <= 4'd0;
    end else if (!cnt_enable) begin
      edge_cnt <= 3'd0;
      bit_cnt  <= 4'd0;
    end else if (edge_cnt == 3'd7) begin
      edge_cnt <= 3'd0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 3'd1;
    end
  end

  // Count high cycles of each pulse output
  always @(negedge CLK) begin
    if (data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (par_err === 1'b1)    pe_cnt <= pe_cnt + 1;
    if (stp_err === 1'b1)    se_cnt <= se_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       par_bit;
    logic       stop_bit;
    logic       flip;
    int         exp_dv;
    int         exp_pe;
    int         exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bit period; optionally corrupts only the edge_cnt==4 sample
  task automatic send_bit(input logic v, input logic flip);
    for (int j = 0; j < 8; j++) begin
      RX_IN = (flip && j == 5) ? ~v : v;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pb, input logic sb, input logic flip);
    PAR_EN  = pe;
    PAR_TYP = pt;
    send_bit(1'b0, 1'b0);
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
    for (int i = 0; i < 8; i++) send_bit(d[i], flip);
    if (pe) send_bit(pb, 1'b0);
    send_bit(sb, 1'b0);
    RX_IN = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    while (cnt_enable !== 1'b0 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check({name, "_idle_timeout"}, int'(n < 50), 1);
  endtask

  initial begin
    int dv0, pe0, se0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h3C};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h55};
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h07};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 8'h07};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1, 8'h07};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cnt_enable", int'(cnt_enable), 0);
    check("rst_p_data",     int'(P_DATA), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_par_err",    int'(par_err), 0);
    check("rst_stp_err",    int'(stp_err), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    for (int i = 0; i < 8; i++) begin
      dv0 = dv_cnt;
      pe0 = pe_cnt;
      se0 = se_cnt;
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].par_bit,
                 vecs[i].stop_bit, vecs[i].flip);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_data_valid", i), dv_cnt - dv0, vecs[i].exp_dv);
      check($sformatf("vec%0d_par_err", i),    pe_cnt - pe0, vecs[i].exp_pe);
      check($sformatf("vec%0d_stp_err", i),    se_cnt - se0, vecs[i].exp_se);
      check($sformatf("vec%0d_p_data", i),     int'(P_DATA), int'(vecs[i].exp_pdata));
    end

    // Two-cycle low glitch: enable rises at once, drops after the first bit-end
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    se0 = se_cnt;
    RX_IN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("glitch_enable_on", int'(cnt_enable), 1);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("glitch_edge7", int'(edge_cnt), 7);
    check("glitch_enable_at_bit_end", int'(cnt_enable), 1);
    @(posedge CLK);
    @(negedge CLK);
    check("glitch_enable_off", int'(cnt_enable), 0);
    repeat (10) @(posedge CLK);
    #1;
    check("glitch_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("glitch_p_data", int'(P_DATA), 8'h07);

    // Back-to-back frames with no idle gap
    dv0 = dv_cnt;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("b2b");
    check("b2b_data_valid", dv_cnt - dv0, 2);
    check("b2b_p_data", int'(P_DATA), 8'h5A);

    // Reset during data bit 4, then a clean frame
    dv0 = dv_cnt;
    pe0 = pe_cnt;
    se0 = se_cnt;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_rst_enable", int'(cnt_enable), 0);
    check("abort_rst_p_data", int'(P_DATA), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    check("abort_enable_idle", int'(cnt_enable), 0);
    check("abort_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle("after_rst");
    check("after_rst_data_valid", dv_cnt - dv0, 1);
    check("after_rst_errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
    check("after_rst_p_data", int'(P_DATA), 8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, sent LSB first.
REQ-002 SHALL have port CLK  input  1  single receiver clock; oversampling is 8x, so one bit is 8 CLK cycles.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle level is 1.
REQ-005 SHALL have port PAR_EN  input  1  parity bit present when 1.
REQ-006 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port bit_cnt  input  4  bit index from the edge/bit counter: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop.
REQ-008 SHALL have port edge_cnt  input  3  oversample index 0..7 within the current bit, from the edge/bit counter.
REQ-009 SHALL have port cnt_enable  output  1  run enable for the edge/bit counter.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  last correctly received byte.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse when a good frame completes.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-013 SHALL have port stp_err  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL sample RX_IN at edge_cnt 3, 4 and 5 and take the majority (2 of 3) as the bit value, registered and valid while edge_cnt==6.
REQ-016 SHALL define bit-end as edge_cnt==7; all state transitions other than IDLE->START SHALL occur only at bit-end.
REQ-017 SHALL, in IDLE, move to START on RX_IN==0, assert cnt_enable in the same cycle, and latch PAR_EN/PAR_TYP for the whole frame.
REQ-018 SHALL, in START at bit-end: go to DATA if the sampled bit is 0; otherwise treat it as a glitch, return to IDLE, deassert cnt_enable and produce no output pulses.
REQ-019 SHALL, in DATA, shift each sampled bit into a DATA_WIDTH shift register LSB first, at edge_cnt==6.
REQ-020 SHALL leave DATA at the bit-end where bit_cnt==DATA_WIDTH: to PARITY if the latched PAR_EN is 1, else to STOP.
REQ-021 SHALL, in PARITY at edge_cnt==6, flag a parity error when the sampled bit differs from XOR(data) (even) or ~XOR(data) (odd).
REQ-022 SHALL, in STOP at edge_cnt==6, flag a stop error when the sampled bit is 0.
REQ-023 SHALL treat the bit-end of STOP as frame-end: return to IDLE and deassert cnt_enable from the next cycle.
REQ-024 SHALL, in the cycle after frame-end, pulse par_err and stp_err if flagged, and pulse data_valid only if neither is flagged.
REQ-025 SHALL load P_DATA from the shift register only on a data_valid pulse and hold it otherwise; an errored frame leaves P_DATA unchanged.
REQ-026 SHALL clear the error flags on every entry to START.
REQ-027 SHALL accept back-to-back frames: RX_IN==0 in the first IDLE cycle after frame-end starts a new frame.
REQ-028 SHALL ignore PAR_EN/PAR_TYP changes mid-frame.
REQ-029 SHALL drive every output from a register; there are no combinational paths from input to output.

Reset
REQ-030 SHALL, while RST==1, force state IDLE, cnt_enable=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, shift register=0, flags=0 and sampler registers=0.
REQ-031 SHALL abandon any frame interrupted by RST with no pulses, and after release wait in IDLE for a fresh falling level.

Structure
REQ-032 SHALL take the state encoding (3-bit), the oversample constant 8, the sample indices 3/4/5 and the bit-end index 7 from the shared package uart_rx_pkg.
REQ-033 SHALL place the 3-sample majority voter in one sub-module, uart_rx_sampler (ports CLK, RST, RX_IN, edge_cnt, enable -> sampled_bit).

Verification
The bench pairs the block with an edge/bit-counter model.
REQ-034 SHALL cover: frame 0xA5, PAR_EN=0, stop=1 -> P_DATA=0xA5, one data_valid pulse, no errors.
REQ-035 SHALL cover: frame 0x3C, PAR_EN=1, PAR_TYP=0, parity bit 0 -> data_valid, P_DATA=0x3C; the same frame with parity bit 1 -> par_err pulse, P_DATA keeps 0xA5.
REQ-036 SHALL cover: frame 0x81 with stop bit 0 -> stp_err pulse, no data_valid.
REQ-037 SHALL cover: a 2-cycle low glitch on idle RX_IN -> return to IDLE at the first bit-end, cnt_enable low, no pulses.
REQ-038 SHALL cover: a single-sample flip at edge_cnt 4 in every data bit of 0x55 -> P_DATA=0x55 (majority vote holds).
REQ-039 SHALL cover: RST pulsed during data bit 4, then a clean 0x0F frame -> no pulses for the aborted frame, then data_valid with P_DATA=0x0F.
